// File: rtl/clk_div_pkg.sv
// ============================================================================
//  Module      : clk_div_pkg
//  Description : Shared constants and ratio helpers for the integer clock divider.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clk_div_pkg;

    localparam int unsigned DIV_MIN = 2;

    // Ratios 0 and 1 cannot produce a two-phase clock, so they fold up to DIV_MIN.
    function automatic int unsigned clamp_div(input int unsigned n);
        return (n < DIV_MIN) ? DIV_MIN : n;
    endfunction

    function automatic int unsigned half_div(input int unsigned n);
        return n >> 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/clk_div_odd50.sv
// ============================================================================
//  Module      : clk_div_odd50
//  Description : Negedge retiming flop and OR stage that stretches the high
//                phase by half a clk period for odd ratios (CLK_DIV_ODD50_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_div_odd50 (
    input  logic clk,
    input  logic rst,
    input  logic q_pos,
    input  logic odd,
    output logic clk_out
);

    logic r_q_neg;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_q_neg <= 1'b0;
        end else begin
            r_q_neg <= q_pos;
        end
    end

    assign clk_out = q_pos | (odd & r_q_neg);

endmodule

`default_nettype wire

// File: rtl/clk_divider_n.sv
// ============================================================================
//  Module      : clk_divider_n
//  Description : Runtime-programmable integer clock divider with tick strobe and
//                boundary-synchronised ratio reload. Define CLK_DIV_ODD50_EN for
//                50% duty on odd ratios.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_divider_n #(
    parameter int DIV_W   = 8,
    parameter int DEF_DIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div_in,
    input  logic             div_load,
    output logic             div_ack,
    output logic [DIV_W-1:0] div_cur,
    output logic             clk_out,
    output logic             tick
);

    import clk_div_pkg::*;

    localparam logic [DIV_W-1:0] DEF_RATIO = DIV_W'(DEF_DIV);
    localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div_cur;
    logic [DIV_W-1:0] r_pend_div;
    logic             r_pend;
    logic             r_q_pos;
    logic             r_tick;
    logic             r_ack;

    logic             w_boundary;
    logic             w_adopt;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic [DIV_W-1:0] w_half;
    logic [DIV_W-1:0] w_load_div;

    assign w_load_div = DIV_W'(clamp_div(32'(div_in)));
    assign w_half     = DIV_W'(half_div(32'(r_div_cur)));
    assign w_cnt_nxt  = r_cnt + ONE;
    assign w_boundary = en && (r_cnt == (r_div_cur - ONE));
    assign w_adopt    = w_boundary && r_pend;

    // Period counter and posedge phase register; a frozen divider holds both.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= DEF_RATIO - ONE;
            r_q_pos <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (w_boundary) begin
                r_cnt   <= '0;
                r_q_pos <= 1'b1;
                r_tick  <= 1'b1;
            end else if (en) begin
                r_cnt   <= w_cnt_nxt;
                r_q_pos <= (w_cnt_nxt < w_half);
            end
        end
    end

    // Active ratio only changes on a boundary, which keeps clk_out glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cur <= DEF_RATIO;
            r_ack     <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            if (w_adopt) begin
                r_div_cur <= r_pend_div;
                r_ack     <= 1'b1;
            end
        end
    end

    // A load on the adopting edge re-arms pend, so it lands at the next boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend     <= 1'b0;
            r_pend_div <= '0;
        end else begin
            if (div_load) begin
                r_pend     <= 1'b1;
                r_pend_div <= w_load_div;
            end else if (w_adopt) begin
                r_pend     <= 1'b0;
            end
        end
    end

`ifdef CLK_DIV_ODD50_EN
    clk_div_odd50 u_odd50 (
        .clk     (clk),
        .rst     (rst),
        .q_pos   (r_q_pos),
        .odd     (r_div_cur[0]),
        .clk_out (clk_out)
    );
`else
    assign clk_out = r_q_pos;
`endif

    assign div_cur = r_div_cur;
    assign div_ack = r_ack;
    assign tick    = r_tick;

endmodule

`default_nettype wire

// File: tb/tb_clk_divider_n.sv
// ============================================================================
//  Module      : tb_clk_divider_n
//  Description : Scoreboard bench for clk_divider_n with a period-position model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clk_divider_n;

    localparam int DIV_W   = 8;
    localparam int DEF_DIV = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [DIV_W-1:0] div_in;
    logic             div_load;
    logic             div_ack;
    logic [DIV_W-1:0] div_cur;
    logic             clk_out;
    logic             tick;

    always #5 clk = ~clk;

    clk_divider_n #(.DIV_W(DIV_W), .DEF_DIV(DEF_DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .div_in   (div_in),
        .div_load (div_load),
        .div_ack  (div_ack),
        .div_cur  (div_cur),
        .clk_out  (clk_out),
        .tick     (tick)
    );

    typedef struct packed {
        logic             clk_out;
        logic             tick;
        logic             ack;
        logic [DIV_W-1:0] cur;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Model: active ratio, position within the period, pending request.
    int   m_n;
    int   m_p;
    int   m_pend_n;
    bit   m_pend;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_n      = DEF_DIV;
        m_p      = DEF_DIV - 1;
        m_pend   = 1'b0;
        m_pend_n = 0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_clk_out"}, int'(clk_out), 0);
        chk({tag, "_tick"},    int'(tick),    0);
        chk({tag, "_ack"},     int'(div_ack), 0);
        chk({tag, "_div_cur"}, int'(div_cur), DEF_DIV);
    endtask

    // Applies one posedge worth of rules to the model and queues the result.
    task automatic model_step(input bit e_en, input bit e_ld, input int e_din);
        exp_t e;
        bit   hi_old;
        bit   hi_new;
        hi_old = (m_p < m_n / 2);
        e      = '0;
        if (e_en) begin
            if (m_p == m_n - 1) begin
                if (m_pend) begin
                    m_n    = m_pend_n;
                    m_pend = 1'b0;
                    e.ack  = 1'b1;
                end
                m_p    = 0;
                e.tick = 1'b1;
            end else begin
                m_p = m_p + 1;
            end
        end
        if (e_ld) begin
            m_pend   = 1'b1;
            m_pend_n = (e_din < 2) ? 2 : e_din;
        end
        hi_new = (m_p < m_n / 2);
`ifdef CLK_DIV_ODD50_EN
        e.clk_out = hi_new | ((m_n % 2 == 1) && hi_old);
`else
        e.clk_out = hi_new;
`endif
        e.cur = DIV_W'(m_n);
        sb_q.push_back(e);
    endtask

    task automatic drive(input bit e_en, input bit e_ld, input int e_din);
        @(negedge clk);
        #1;
        en       = e_en;
        div_load = e_ld;
        div_in   = DIV_W'(e_din);
        model_step(e_en, e_ld, e_din);
    endtask

    // Monitor: every posedge outside reset presents one output sample.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (!rst && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("clk_out", int'(clk_out), int'(e.clk_out));
                chk("tick",    int'(tick),    int'(e.tick));
                chk("div_ack", int'(div_ack), int'(e.ack));
                chk("div_cur", int'(div_cur), int'(e.cur));
            end
        end
    end

    initial begin
        int din;
        bit r_en;
        bit r_ld;

        rst      = 1'b1;
        en       = 1'b0;
        div_load = 1'b0;
        div_in   = '0;
        model_reset();
        #3;
        check_reset("por");
        #19;
        rst = 1'b0;

        // Default ratio
        repeat (8) drive(1, 0, 0);

        // Establish N=8, then several loads inside one period: last wins
        drive(1, 1, 8);
        repeat (12) drive(1, 0, 0);
        drive(1, 1, 4);
        drive(1, 1, 3);
        drive(1, 1, 6);
        repeat (16) drive(1, 0, 0);

        // Odd ratio
        drive(1, 1, 5);
        repeat (25) drive(1, 0, 0);

        // Clamped ratios
        drive(1, 1, 0);
        repeat (10) drive(1, 0, 0);
        drive(1, 1, 1);
        repeat (10) drive(1, 0, 0);

        // Freeze during the high phase of N=6
        drive(1, 1, 6);
        repeat (8) drive(1, 0, 0);
        for (int i = 0; i < 12 && m_p != 0; i++) drive(1, 0, 0);
        drive(1, 0, 0);
        repeat (3) drive(0, 0, 0);
        repeat (12) drive(1, 0, 0);

        // Maximum ratio, plus a reload equal to the active ratio
        drive(1, 1, 255);
        repeat (260) drive(1, 0, 0);
        drive(1, 1, 255);
        repeat (260) drive(1, 0, 0);

        // Asynchronous reset mid-period with a pending load
        drive(1, 1, 9);
        repeat (12) drive(1, 0, 0);
        drive(1, 1, 7);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_reset("async_rst");
        chk("sb_drained_at_rst", sb_q.size(), 0);
        sb_q.delete();
        model_reset();
        @(posedge clk);
        #3;
        check_reset("rst_held");
        rst = 1'b0;
        #1;
        check_reset("rst_release");
        repeat (10) drive(1, 0, 0);

        // Randomised traffic
        repeat (800) begin
            r_en = ($urandom_range(0, 9) != 0);
            r_ld = ($urandom_range(0, 7) == 0);
            din  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255))
                                               : int'($urandom_range(0, 12));
            drive(r_en, r_ld, din);
        end

        @(posedge clk);
        #4;
        chk("sb_drained_at_end", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
